// File: rtl/pwm_measure.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input in core-clock
// cycles, and flags stuck-line and counter-saturation conditions.
module pwm_measure #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 50000
) (
    input  logic             clkCore,
    input  logic             reset_b,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             overflow,
    output logic             stuck,
    output logic             stuck_level
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, prev, rise, fall, edge_seen, timeout_hit;

    state_t           state, state_n;
    logic [CNT_W-1:0] hcnt, hcnt_n, pcnt, pcnt_n, tcnt, tcnt_n, tcnt_inc;
    logic             sat, sat_n;
    logic [CNT_W-1:0] high_n, period_n;
    logic             valid_n, ovf_n, stuck_n, level_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) prev <= 1'b0;
        else          prev <= s;
    end

    assign rise        = s & ~prev;
    assign fall        = ~s & prev;
    assign edge_seen   = rise | fall;
    assign tcnt_inc    = sat_inc(tcnt);
    assign timeout_hit = (state != IDLE) && !edge_seen && (tcnt_inc == TIMEOUT_C);

    always_comb begin
        state_n  = state;
        hcnt_n   = hcnt;
        pcnt_n   = pcnt;
        tcnt_n   = tcnt;
        sat_n    = sat;
        high_n   = high_cnt;
        period_n = period_cnt;
        valid_n  = 1'b0;
        ovf_n    = overflow;
        stuck_n  = stuck;
        level_n  = stuck_level;

        if (!en) begin
            // Disable wins over any edge or timeout; published results are kept.
            state_n = IDLE;
            hcnt_n  = '0;
            pcnt_n  = '0;
            tcnt_n  = '0;
            sat_n   = 1'b0;
        end else begin
            tcnt_n = edge_seen ? '0 : tcnt_inc;
            case (state)
                IDLE: begin
                    state_n = ARM;
                    hcnt_n  = '0;
                    pcnt_n  = '0;
                    tcnt_n  = '0;
                    sat_n   = 1'b0;
                end
                ARM: begin
                    if (rise) begin
                        hcnt_n  = CNT_ONE;
                        pcnt_n  = CNT_ONE;
                        sat_n   = 1'b0;
                        stuck_n = 1'b0;
                        state_n = HIGH;
                    end
                end
                HIGH: begin
                    pcnt_n = sat_inc(pcnt);
                    if (fall) state_n = LOW;
                    else      hcnt_n  = sat_inc(hcnt);
                end
                default: begin
                    if (rise) begin
                        high_n   = hcnt;
                        period_n = pcnt;
                        ovf_n    = sat;
                        valid_n  = 1'b1;
                        hcnt_n   = CNT_ONE;
                        pcnt_n   = CNT_ONE;
                        sat_n    = 1'b0;
                        state_n  = HIGH;
                    end else begin
                        pcnt_n = sat_inc(pcnt);
                    end
                end
            endcase

            if ((state == HIGH || state == LOW) && pcnt_n == CNT_MAX) sat_n = 1'b1;

            // A timeout can only fire on an edge-free cycle, so it never collides with a publish.
            if (timeout_hit) begin
                stuck_n = 1'b1;
                level_n = s;
                state_n = ARM;
                hcnt_n  = '0;
                pcnt_n  = '0;
                tcnt_n  = '0;
                sat_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clkCore or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            hcnt        <= '0;
            pcnt        <= '0;
            tcnt        <= '0;
            sat         <= 1'b0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            meas_valid  <= 1'b0;
            overflow    <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            pcnt        <= pcnt_n;
            tcnt        <= tcnt_n;
            sat         <= sat_n;
            high_cnt    <= high_n;
            period_cnt  <= period_n;
            meas_valid  <= valid_n;
            overflow    <= ovf_n;
            stuck       <= stuck_n;
            stuck_level <= level_n;
        end
    end

endmodule

// File: doc/pwm_measure.md
Name: pwm_measure

Overview:
- Receive-side counterpart of the vernier PWM generator.
- Samples an asynchronous PWM waveform on the 200 MHz core clock and measures, in clkCore cycles, the high time and the period between consecutive rising edges.
- Publishes each completed period as a registered measurement with a one-cycle valid strobe.
- Flags stuck-high, stuck-low and counter-overflow conditions.
- Used to close the loop on photonic switch drive and to check generator settings on the bench.

Parameters:
- CNT_W, 16, width of the high-time and period counters and outputs.
- SYNC_STAGES, 2, number of synchroniser flops on pwm_in (legal range 2..4).
- TIMEOUT, 50000, cycles without any edge before stuck is declared (legal range 2..2^CNT_W-1).

Ports:
- clkCore  input  1  200 MHz core clock; the only clock.
- reset_b  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable.
- pwm_in  input  1  PWM signal, asynchronous to clkCore.
- high_cnt  output  CNT_W  high time of last completed period, in cycles.
- period_cnt  output  CNT_W  rising-to-rising period of last completed period, in cycles.
- meas_valid  output  1  one-cycle strobe when high_cnt/period_cnt update.
- overflow  output  1  last published period saturated its counter.
- stuck  output  1  no edge seen for TIMEOUT cycles.
- stuck_level  output  1  synchronised pwm_in level when stuck was set.

Behaviour:
- Reset (reset_b=0, async): all outputs 0, synchroniser flops 0, internal counters 0, state IDLE.
- Synchroniser: pwm_in passes through a SYNC_STAGES flop chain; its last stage is s.
  - prev is s delayed one cycle.
  - rise = s & ~prev; fall = ~s & prev.
- FSM states: IDLE, ARM, HIGH, LOW.
- IDLE:
  - Counters held at 0.
  - en=1 moves to ARM on the next cycle.
- ARM:
  - Waits for rise; no measurement is published for the partial period.
  - On rise: hcnt=1, pcnt=1, tcnt=0, stuck cleared, go to HIGH.
- HIGH:
  - Each cycle pcnt+1 and hcnt+1.
  - On fall: hcnt frozen (the fall cycle is not counted), pcnt+1, go to LOW.
- LOW:
  - Each cycle pcnt+1.
  - On rise, publish high_cnt<=hcnt, period_cnt<=pcnt and overflow<=sat, and pulse meas_valid for exactly 1 cycle.
  - In the same cycle reload hcnt=1, pcnt=1, sat=0, then go to HIGH.
- Result: for a clean waveform of H cycles high and P cycles period, high_cnt=H and period_cnt=P.
- Latency:
  - pwm_in first sampled high at clkCore edge 0 gives meas_valid=1 in the cycle after edge SYNC_STAGES.
  - With SYNC_STAGES=2, that is edge 2.
- Saturation:
  - hcnt and pcnt stop at 2^CNT_W-1 and never wrap.
  - pcnt reaching all-ones sets sat, which is reported via overflow on the next publish.
- Timeout:
  - tcnt counts cycles since the last rise or fall, in ARM, HIGH and LOW.
  - When tcnt reaches TIMEOUT: stuck=1, stuck_level=s, go to ARM.
  - high_cnt, period_cnt and overflow are unchanged and meas_valid does not pulse.
  - stuck stays 1 until the next rise in ARM.
- en=0 (any state):
  - Next state is IDLE; internal counters cleared; meas_valid 0.
  - high_cnt, period_cnt, overflow, stuck and stuck_level hold their values.
  - en=0 takes priority over a simultaneous rise, fall or timeout.
- Simultaneous events:
  - A rise in the same cycle as timeout: the rise wins (edge resets tcnt).
  - A one-cycle-wide high pulse is legal: H=1.
- Mid-operation reset: immediately returns to reset values; after release, the first publish requires ARM plus one full period.
- Synchroniser flops carry no other logic; meas_valid and all outputs are registered.

Test Plan:
- Basic period: reset, en=1, pwm_in with 50 cycles high / 150 low for 4 periods.
  - Required: 3 meas_valid strobes, each with high_cnt=50, period_cnt=200, overflow=0.
  - First strobe arrives SYNC_STAGES cycles after the 2nd rising edge is sampled.
- Duty extremes: 1 high / 199 low gives high_cnt=1, period_cnt=200; 199 high / 1 low gives high_cnt=199, period_cnt=200.
- Overflow (CNT_W=8): period 300, 100 high.
  - Required: period_cnt=255, high_cnt=100, overflow=1.
  - A following period of 200 gives overflow=0.
- Stuck (TIMEOUT=1000): after a valid period, hold pwm_in high 1500 cycles.
  - Required: stuck=1 and stuck_level=1 exactly 1000 cycles after the synchronised last edge; outputs unchanged; no meas_valid.
  - The next rise clears stuck, and the following period publishes normally.
- Enable/reset mid-period: deassert en during HIGH.
  - Required: meas_valid stays 0 and outputs hold.
  - Re-enable: the first strobe comes only after ARM plus a full period.
  - Repeat using reset_b=0 mid-LOW: all outputs read 0 asynchronously.
